result_demux4: RTL and testbench
================================

Name: result_demux4

Overview:
- Write-back distributor for the elliptic-curve datapath. It is the opposite end of the 4:1 operand selector: it takes one signed 256-bit result and routes it to one of four destinations (unicast) or to all four (broadcast).
- Results are buffered in a small FIFO so the arithmetic units are not stalled by a slow consumer.
- Each destination has its own valid/ready handshake. A broadcast entry retires only after all four destinations have accepted it.

Parameters:
- DATA_W, 256, result width in bits; data is treated as signed and passed through bit-exact.
- DEPTH, 2, FIFO entries; must be a power of 2 and >= 2.
- NUM_DEST, 4, number of destinations; fixed at 4, parameterised for the package only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  block can accept a result; equals !full.
- in_data  in  DATA_W  signed result.
- in_select  in  2  destination index 0..3; ignored when in_bcast=1.
- in_bcast  in  1  deliver to all four destinations.
- out_valid  out  4  per-destination valid, one bit per destination.
- out_ready  in  4  per-destination ready, one bit per destination.
- out_data  out  DATA_W  head-entry data, shared by all destinations.
- occupancy  out  $clog2(DEPTH+1)  number of entries held.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, ack_done=0. Resulting outputs: occupancy=0, in_ready=1, out_valid=0, out_data=0.
- Push: in_valid & in_ready at an edge writes {in_data, dest_mask} at the write pointer.
  - dest_mask = 4'b1111 if in_bcast=1, else the one-hot of in_select.
- Head presentation:
  - out_valid = (occupancy!=0) ? (head_mask & ~ack_done) : 0.
  - out_data = head data when non-empty, else 0.
- Per-destination accept: out_valid[i] & out_ready[i] at an edge sets ack_done[i].
- Pop: at an edge where (ack_done | accepted_this_cycle) == head_mask.
  - The read pointer advances and ack_done clears to 0.
  - The next entry is presented in the following cycle; no bubble.
- Latency: empty FIFO, push at edge N -> out_valid asserted during cycle N+1.
- Sustained throughput: one entry per cycle with a unicast stream and the target's ready held high.
- Full: in_ready=0; in_valid is ignored with no overwrite and no error.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous push and pop:
  - Allowed whenever not full; occupancy stays unchanged.
  - There is no combinational in-to-out bypass, even when empty.
- Broadcast:
  - Destinations may accept in any cycles, in any order, or all in the same cycle.
  - Once a destination has accepted, its out_valid bit drops and stays low until the next entry.
- Wrap-around: pointers wrap modulo DEPTH; full/empty are derived from the occupancy counter.
- Stability: while out_valid[i]=1, out_data and that bit must not change until accepted (AXI-style, no retraction).
- Reset mid-operation: all entries discarded, no partial delivery completed, and outputs return to reset values immediately.
- Value rule: data is never modified (signed values pass bit-exact), e.g. -1 stays all ones.

Decomposition:
- Package ec_route_pkg:
  - constants DATA_W=256, NUM_DEST=4, SEL_W=2;
  - typedef dest_mask_t (4 bits);
  - function sel_to_mask(sel, bcast).
- Sub-module result_fifo: DEPTH x (DATA_W+4) storage, pointers, occupancy, full/empty.
- Top level: ack_done register, out_valid generation and pop logic.

Test Plan:
- Unicast, all ready: push data=5 sel=2 -> the next cycle out_valid=4'b0100, out_data=5; entry pops on the same edge; occupancy goes 1->0.
- Back-pressure/full (DEPTH=2): out_ready=0, push 0xA then 0xB -> in_ready=0, a third push of 0xC is not taken; release out_ready -> 0xA then 0xB are delivered; 0xC never appears.
- Broadcast, staggered ready: push -1 with bcast.
  - out_ready=0001 at t0 -> out_valid becomes 1110.
  - out_ready=0110 at t1 -> out_valid becomes 1000.
  - out_ready=1000 at t2 -> pop; out_data was all ones throughout.
- Back-to-back mixed: push sel=0, then bcast, then sel=3, all ready=1111 -> out_valid sequence 0001, 1111, 1000 on consecutive cycles; no bubbles.
- Simultaneous push/pop at occupancy=1 -> occupancy stays 1 and data order is preserved.
- Reset mid-broadcast: assert reset_n=0 with ack_done=0011 -> out_valid=0, occupancy=0, in_ready=1 immediately; after release, the first push is delivered normally.

Source files
------------

// File: rtl/ec_route_pkg.sv
// rtl/ec_route_pkg.sv - shared constants, types and helpers for result routing
//   DATA_W      : result width in bits
//   NUM_DEST    : number of write-back destinations
//   SEL_W       : destination index width
//   dest_mask_t : one bit per destination
//   sel_to_mask : index/broadcast request -> destination mask
package ec_route_pkg;

    localparam int DATA_W   = 256;
    localparam int NUM_DEST = 4;
    localparam int SEL_W    = 2;

    typedef logic [NUM_DEST-1:0] dest_mask_t;

    // Broadcast targets every destination; otherwise a one-hot of the index.
    function automatic dest_mask_t sel_to_mask(input logic [SEL_W-1:0] sel, input logic bcast);
        dest_mask_t m;
        if (bcast) begin
            m = '1;
        end else begin
            m = dest_mask_t'(1) << sel;
        end
        return m;
    endfunction

endpackage

// File: rtl/result_demux4_if.sv
// rtl/result_demux4_if.sv - producer and destination handshake bundle for result_demux4
//   in_valid/in_ready/in_data/in_select/in_bcast : producer side
//   out_valid/out_ready (per destination), out_data (shared) : destination side
//   occupancy : entries currently buffered
//   slave  modport : the distributor
//   master modport : the environment driving it
interface result_demux4_if #(
    parameter int DATA_W = ec_route_pkg::DATA_W,
    parameter int DEPTH  = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_W-1:0]               in_data;
    logic [ec_route_pkg::SEL_W-1:0]  in_select;
    logic                            in_bcast;
    ec_route_pkg::dest_mask_t        out_valid;
    ec_route_pkg::dest_mask_t        out_ready;
    logic [DATA_W-1:0]               out_data;
    logic [OCC_W-1:0]                occupancy;

    modport slave (
        input  in_valid, in_data, in_select, in_bcast, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, in_select, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - DEPTH-entry FIFO of {data, destination mask}
//   clk, reset_n            : clock, async active-low reset
//   push, push_data/mask    : write an entry (caller guarantees !full)
//   pop                     : retire the head (caller guarantees !empty)
//   head_data, head_mask    : entry at the read pointer
//   occupancy, full, empty  : fill state derived from the entry counter
module result_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 2,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  ec_route_pkg::dest_mask_t push_mask,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output ec_route_pkg::dest_mask_t head_mask,
    output logic [OCC_W-1:0]         occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]        mem_data [DEPTH];
    ec_route_pkg::dest_mask_t mem_mask [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [OCC_W-1:0]         count;

    assign full      = (count == OCC_W'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign head_data = mem_data[rd_ptr];
    assign head_mask = mem_mask[rd_ptr];

    // Storage carries no reset: contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_mask[wr_ptr] <= push_mask;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_demux4.sv
// rtl/result_demux4.sv - buffered unicast/broadcast write-back distributor
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : result_demux4_if.slave (producer push, per-destination
//             valid/ready, shared out_data, occupancy)
module result_demux4
    import ec_route_pkg::dest_mask_t;
    import ec_route_pkg::sel_to_mask;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    result_demux4_if.slave  bus
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] head_data;
    dest_mask_t        head_mask;
    dest_mask_t        ack_done;
    dest_mask_t        accepted;
    logic [OCC_W-1:0]  occupancy;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign push = bus.in_valid && !full;

    // Destinations that already took the head are masked off so a broadcast
    // entry is delivered exactly once to each.
    assign bus.out_valid = empty ? '0 : (head_mask & ~ack_done);
    assign bus.out_data  = empty ? '0 : head_data;
    assign accepted      = bus.out_valid & bus.out_ready;

    // ack_done only ever holds bits of head_mask, so equality means every
    // targeted destination has now taken the entry.
    assign pop = !empty && ((ack_done | accepted) == head_mask);

    assign bus.in_ready  = !full;
    assign bus.occupancy = occupancy;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OCC_W  (OCC_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.in_data),
        .push_mask (sel_to_mask(bus.in_select, bus.in_bcast)),
        .pop       (pop),
        .head_data (head_data),
        .head_mask (head_mask),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_done <= '0;
        end else if (pop) begin
            ack_done <= '0;
        end else begin
            ack_done <= ack_done | accepted;
        end
    end

endmodule

// File: tb/tb_result_demux4.sv
// tb/tb_result_demux4.sv - directed self-checking bench for result_demux4
module tb_result_demux4;

    localparam int DATA_W = 256;
    localparam int DEPTH  = 2;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [DATA_W-1:0] ones;

    result_demux4_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    result_demux4 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and samples both live 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] sel, input logic bc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_select = sel;
        bus.in_bcast  = bc;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ones     = '1;
        reset_n  = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0);
        bus.out_ready = 4'b0000;
        step();
        step();

        check("rst_occ",    DATA_W'(bus.occupancy), 0);
        check("rst_in_rdy", DATA_W'(bus.in_ready),  1);
        check("rst_oval",   DATA_W'(bus.out_valid), 0);
        check("rst_odata",  bus.out_data,           0);
        reset_n = 1'b1;
        step();

        // Unicast to destination 2, ready held high.
        bus.out_ready = 4'b0100;
        drive(1'b1, 256'd5, 2'd2, 1'b0);
        check("uni_no_bypass", DATA_W'(bus.out_valid), 0);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("uni_oval",  DATA_W'(bus.out_valid), 4'b0100);
        check("uni_odata", bus.out_data,           5);
        check("uni_occ1",  DATA_W'(bus.occupancy), 1);
        step();
        check("uni_occ0",  DATA_W'(bus.occupancy), 0);
        check("uni_empty", DATA_W'(bus.out_valid), 0);

        // Fill with no ready, third push must be dropped.
        bus.out_ready = 4'b0000;
        drive(1'b1, 256'hA, 2'd0, 1'b0);
        step();
        drive(1'b1, 256'hB, 2'd1, 1'b0);
        step();
        check("full_in_rdy", DATA_W'(bus.in_ready),  0);
        check("full_occ",    DATA_W'(bus.occupancy), 2);
        drive(1'b1, 256'hC, 2'd2, 1'b0);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("full_hold_occ",  DATA_W'(bus.occupancy), 2);
        check("full_hold_data", bus.out_data,           256'hA);
        bus.out_ready = 4'b1111;
        #1;
        check("drain_a_oval", DATA_W'(bus.out_valid), 4'b0001);
        step();
        check("drain_b_oval", DATA_W'(bus.out_valid), 4'b0010);
        check("drain_b_data", bus.out_data,           256'hB);
        check("drain_b_occ",  DATA_W'(bus.occupancy), 1);
        step();
        check("drain_done_occ", DATA_W'(bus.occupancy), 0);
        step();
        check("no_c_oval", DATA_W'(bus.out_valid), 0);

        // Broadcast of -1 with staggered accepts.
        bus.out_ready = 4'b0000;
        drive(1'b1, ones, 2'd1, 1'b1);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("bc_oval0", DATA_W'(bus.out_valid), 4'b1111);
        check("bc_data0", bus.out_data,           ones);
        bus.out_ready = 4'b0001;
        step();
        check("bc_oval1", DATA_W'(bus.out_valid), 4'b1110);
        check("bc_data1", bus.out_data,           ones);
        bus.out_ready = 4'b0110;
        step();
        check("bc_oval2", DATA_W'(bus.out_valid), 4'b1000);
        check("bc_data2", bus.out_data,           ones);
        check("bc_occ2",  DATA_W'(bus.occupancy), 1);
        bus.out_ready = 4'b1000;
        step();
        check("bc_pop_occ",  DATA_W'(bus.occupancy), 0);
        check("bc_pop_oval", DATA_W'(bus.out_valid), 0);

        // Back-to-back sel0, bcast, sel3 with all ready: no bubbles.
        bus.out_ready = 4'b1111;
        drive(1'b1, 256'd1, 2'd0, 1'b0);
        step();
        drive(1'b1, 256'd2, 2'd1, 1'b1);
        check("b2b_oval0", DATA_W'(bus.out_valid), 4'b0001);
        check("b2b_data0", bus.out_data,           1);
        step();
        drive(1'b1, 256'd3, 2'd3, 1'b0);
        check("b2b_oval1", DATA_W'(bus.out_valid), 4'b1111);
        check("b2b_data1", bus.out_data,           2);
        check("b2b_occ1",  DATA_W'(bus.occupancy), 1);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("b2b_oval2", DATA_W'(bus.out_valid), 4'b1000);
        check("b2b_data2", bus.out_data,           3);
        check("b2b_occ2",  DATA_W'(bus.occupancy), 1);
        step();
        check("b2b_end_occ", DATA_W'(bus.occupancy), 0);

        // Reset while a broadcast is half delivered.
        bus.out_ready = 4'b0000;
        drive(1'b1, 256'd7, 2'd0, 1'b1);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        bus.out_ready = 4'b0011;
        step();
        bus.out_ready = 4'b0000;
        check("mid_oval", DATA_W'(bus.out_valid), 4'b1100);
        reset_n = 1'b0;
        #1;
        check("mid_rst_oval",  DATA_W'(bus.out_valid), 0);
        check("mid_rst_occ",   DATA_W'(bus.occupancy), 0);
        check("mid_rst_rdy",   DATA_W'(bus.in_ready),  1);
        check("mid_rst_odata", bus.out_data,           0);
        step();
        reset_n = 1'b1;
        step();
        bus.out_ready = 4'b0010;
        drive(1'b1, 256'd9, 2'd1, 1'b0);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("post_oval", DATA_W'(bus.out_valid), 4'b0010);
        check("post_data", bus.out_data,           9);
        step();
        check("post_occ", DATA_W'(bus.occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
